// File: rtl/memory_arbiter.sv
// Two-requester memory arbiter: instruction fetch vs. load/store, one outstanding
// transaction, data-preferred with a starvation guard for instruction fetches.
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instructionRequest,
  input  logic [31:0] instructionAddress,
  input  logic        instructionFlush,
  output logic [31:0] instructionData,
  output logic        instructionDataValid,
  input  logic        dataRequest,
  input  logic        dataWrite,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataWriteData,
  input  logic [3:0]  dataByteEnable,
  output logic [31:0] dataReadData,
  output logic        dataDone,
  output logic        memRequest,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  memByteEnable,
  input  logic        memReady,
  input  logic        memReadValid,
  input  logic [31:0] memReadData
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D, RESPOND
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_next;
  logic [3:0] starve_count, starve_count_next;
  logic       discard, discard_next;
  logic       serving_instr;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next        = state;
    starve_count_next = starve_count;
    discard_next      = discard;
    case (state)
      IDLE: begin
        if (dataRequest && instructionRequest) begin
          if (starve_count == LIMIT) begin
            state_next = ISSUE_I;
          end else begin
            state_next        = ISSUE_D;
            starve_count_next = starve_count + 4'd1;
          end
        end else if (dataRequest) begin
          state_next = ISSUE_D;
        end else if (instructionRequest) begin
          state_next = ISSUE_I;
        end
      end
      ISSUE_I: if (memReady)     state_next = WAIT_I;
      ISSUE_D: if (memReady)     state_next = WAIT_D;
      WAIT_I:  if (memReadValid) state_next = RESPOND;
      WAIT_D:  if (memReadValid) state_next = RESPOND;
      RESPOND: begin
        state_next   = IDLE;
        discard_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase

    if (state == IDLE && state_next == ISSUE_I) starve_count_next = 4'd0;

    // A redirect only kills a fetch that is being chosen, offered, or awaited.
    if (instructionFlush &&
        (state == ISSUE_I || state == WAIT_I || (state == IDLE && state_next == ISSUE_I)))
      discard_next = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      starve_count    <= 4'd0;
      discard         <= 1'b0;
      serving_instr   <= 1'b0;
      memWrite        <= 1'b0;
      memAddress      <= '0;
      memWriteData    <= '0;
      memByteEnable   <= '0;
      instructionData <= '0;
      dataReadData    <= '0;
    end else begin
      state        <= state_next;
      starve_count <= starve_count_next;
      discard      <= discard_next;

      if (state == IDLE && state_next != IDLE) begin
        if (state_next == ISSUE_I) begin
          serving_instr <= 1'b1;
          memWrite      <= 1'b0;
          memAddress    <= instructionAddress;
          memWriteData  <= '0;
          memByteEnable <= 4'hF;
        end else begin
          serving_instr <= 1'b0;
          memWrite      <= dataWrite;
          memAddress    <= dataAddress;
          memWriteData  <= dataWriteData;
          memByteEnable <= dataByteEnable;
        end
      end

      if (memReadValid && state == WAIT_I && !discard_next) instructionData <= memReadData;
      if (memReadValid && state == WAIT_D)                  dataReadData    <= memReadData;
    end
  end

  assign memRequest           = (state == ISSUE_I) || (state == ISSUE_D);
  assign instructionDataValid = (state == RESPOND) && serving_instr && !discard;
  assign dataDone             = (state == RESPOND) && !serving_instr;

  a_req_only_in_issue : assert property (@(posedge clock) disable iff (reset)
    memRequest |-> (state == ISSUE_I || state == ISSUE_D));
  a_one_outstanding : assert property (@(posedge clock) disable iff (reset)
    (state == WAIT_I || state == WAIT_D || state == RESPOND) |-> !memRequest);
  a_done_one_cycle : assert property (@(posedge clock) disable iff (reset)
    (instructionDataValid || dataDone) |=> !(instructionDataValid || dataDone));
  a_fields_stable : assert property (@(posedge clock) disable iff (reset)
    (memRequest && !memReady) |=>
      ($stable(memAddress) && $stable(memWrite) && $stable(memWriteData) && $stable(memByteEnable)));

endmodule
